// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline control sequencer.
//   seq_state_e      - sequencer states
//   PC_SRC_*         - PC source select encodings
//   DEF_*            - default vector addresses and drain length
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST_VEC,
    ST_RUN,
    ST_DRAIN,
    ST_PUSH_PC,
    ST_PUSH_FLAGS,
    ST_VECTOR
  } seq_state_e;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_VEC = 2'd2;

  localparam logic [7:0]  DEF_RESET_VEC    = 8'h00;
  localparam logic [7:0]  DEF_INTR_VEC     = 8'h01;
  localparam int unsigned DEF_DRAIN_CYCLES = 3;

endpackage

// File: rtl/pipe_sequencer_if.sv
// pipe_sequencer_if: control bundle between the hazard unit / pipeline and
// the sequencer.
//   master modport (sequencer): takes stall/stall_pc/branch_taken_ex/intr/
//     rti_commit, drives PC enable/select, stage enables/flushes, push
//     strobes, interrupt status, busy and stall_cnt.
//   slave modport (pipeline side): the mirror image.
interface pipe_sequencer_if;
  logic        stall;
  logic        stall_pc;
  logic        branch_taken_ex;
  logic        intr;
  logic        rti_commit;
  logic        pc_en;
  logic [1:0]  pc_src;
  logic [7:0]  vec_addr;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        push_pc;
  logic        push_flags;
  logic        intr_ack;
  logic        intr_masked;
  logic        busy;
  logic [15:0] stall_cnt;

  modport master (
    input  stall, stall_pc, branch_taken_ex, intr, rti_commit,
    output pc_en, pc_src, vec_addr, if_id_en, if_id_flush, id_ex_flush,
           push_pc, push_flags, intr_ack, intr_masked, busy, stall_cnt
  );

  modport slave (
    output stall, stall_pc, branch_taken_ex, intr, rti_commit,
    input  pc_en, pc_src, vec_addr, if_id_en, if_id_flush, id_ex_flush,
           push_pc, push_flags, intr_ack, intr_masked, busy, stall_cnt
  );
endinterface

// File: rtl/pipe_stall_counter.sv
// pipe_stall_counter: 16-bit saturating event counter, cleared only by reset.
//   clk, rst_n - clock, async active-low reset
//   inc_i      - count one event this cycle
//   count_o    - current count, holds at 16'hFFFF
module pipe_stall_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [15:0] count_o
);
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: pipeline control sequencer for the 4-stage 8-bit core.
// Converts stall / branch / interrupt requests into PC and stage controls
// and runs the reset-vector and interrupt-entry sequences
// (drain, push PC, push flags, load vector).
//   clk, rst_n - clock, async active-low reset
//   bus        - pipe_sequencer_if.master (requests in, controls out)
// Parameters: DRAIN_CYCLES (1..7), RESET_VEC, INTR_VEC.
// Optional: define PIPE_PERF_CNT_EN to build the saturating stall counter;
// otherwise stall_cnt reads 0.
module pipe_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter logic [7:0]  RESET_VEC    = DEF_RESET_VEC,
  parameter logic [7:0]  INTR_VEC     = DEF_INTR_VEC
) (
  input logic              clk,
  input logic              rst_n,
  pipe_sequencer_if.master bus
);
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  seq_state_e state_q;
  logic [2:0] drain_q;
  logic       intr_pend_q;
  logic       intr_masked_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RST_VEC;
      drain_q       <= '0;
      intr_pend_q   <= 1'b0;
      intr_masked_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RST_VEC: state_q <= ST_RUN;
        ST_RUN: begin
          if (!bus.branch_taken_ex && intr_pend_q) begin
            state_q <= ST_DRAIN;
            drain_q <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) state_q <= ST_PUSH_PC;
          else               drain_q <= drain_q - 3'd1;
        end
        ST_PUSH_PC:    state_q <= ST_PUSH_FLAGS;
        ST_PUSH_FLAGS: state_q <= ST_VECTOR;
        ST_VECTOR:     state_q <= ST_RUN;
        default:       state_q <= ST_RST_VEC;
      endcase

      // Acknowledge wins over a same-cycle request: the accepted request is consumed.
      if (state_q == ST_VECTOR)                  intr_pend_q <= 1'b0;
      else if (bus.intr && !intr_masked_q)       intr_pend_q <= 1'b1;

      if (state_q == ST_VECTOR)                  intr_masked_q <= 1'b1;
      else if (bus.rti_commit)                   intr_masked_q <= 1'b0;
    end
  end

  // rst_n gates the outputs so reset shows the idle values rather than the
  // vector-fetch values that RST_VEC presents on the first cycle after release.
  always_comb begin
    bus.pc_en       = 1'b0;
    bus.pc_src      = PC_SRC_SEQ;
    bus.vec_addr    = '0;
    bus.if_id_en    = 1'b0;
    bus.if_id_flush = 1'b1;
    bus.id_ex_flush = 1'b1;
    bus.push_pc     = 1'b0;
    bus.push_flags  = 1'b0;
    bus.intr_ack    = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_RST_VEC: begin
          bus.pc_en    = 1'b1;
          bus.pc_src   = PC_SRC_VEC;
          bus.vec_addr = RESET_VEC;
        end
        ST_RUN: begin
          if (bus.branch_taken_ex) begin
            bus.pc_en    = 1'b1;
            bus.pc_src   = PC_SRC_BR;
            bus.if_id_en = 1'b1;
          end else begin
            bus.pc_en       = ~bus.stall_pc;
            bus.if_id_en    = ~bus.stall;
            bus.if_id_flush = 1'b0;
            bus.id_ex_flush = bus.stall;
          end
        end
        ST_DRAIN: begin
          // A branch resolving during drain still redirects the PC so the
          // saved return address is the branch target.
          if (bus.branch_taken_ex) begin
            bus.pc_en  = 1'b1;
            bus.pc_src = PC_SRC_BR;
          end
        end
        ST_PUSH_PC:    bus.push_pc    = 1'b1;
        ST_PUSH_FLAGS: bus.push_flags = 1'b1;
        ST_VECTOR: begin
          bus.pc_en    = 1'b1;
          bus.pc_src   = PC_SRC_VEC;
          bus.vec_addr = INTR_VEC;
          bus.intr_ack = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.intr_masked = intr_masked_q;
  assign bus.busy        = (state_q != ST_RUN);

`ifdef PIPE_PERF_CNT_EN
  logic        stall_inc;
  logic [15:0] stall_cnt;
  assign stall_inc = (state_q == ST_RUN) && !bus.branch_taken_ex &&
                     (bus.stall || bus.stall_pc);
  pipe_stall_counter u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (stall_inc),
    .count_o (stall_cnt)
  );
  assign bus.stall_cnt = stall_cnt;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer: self-checking bench for pipe_sequencer. A cycle-level
// reference model tracks the interrupt entry as a position in a fixed
// timeline (drain slots, then push PC, push flags, vector) and predicts every
// output each cycle under directed and random stimulus.
module tb_pipe_sequencer;
  import pipe_ctrl_pkg::*;

  localparam int D = 3;
  localparam logic [7:0] RV = 8'h00;
  localparam logic [7:0] IV = 8'h01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_sequencer_if bus ();

  pipe_sequencer #(.DRAIN_CYCLES(D), .RESET_VEC(RV), .INTR_VEC(IV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_vecfetch;   // first cycle after reset release
  int m_pos;        // -1 = normal running, else index in the entry timeline
  bit m_pend;
  bit m_masked;
  int m_scnt;
  bit last_ack;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_scnt();
`ifdef PIPE_PERF_CNT_EN
    return 16'(m_scnt);
`else
    return 16'h0;
`endif
  endfunction

  task automatic model_reset();
    m_vecfetch = 1'b1;
    m_pos      = -1;
    m_pend     = 1'b0;
    m_masked   = 1'b0;
    m_scnt     = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".pc_en"},   bus.pc_en, 0);
    check({tag, ".pc_src"},  bus.pc_src, 0);
    check({tag, ".vec"},     bus.vec_addr, 0);
    check({tag, ".if_en"},   bus.if_id_en, 0);
    check({tag, ".if_fl"},   bus.if_id_flush, 1);
    check({tag, ".id_fl"},   bus.id_ex_flush, 1);
    check({tag, ".push_pc"}, bus.push_pc, 0);
    check({tag, ".push_fl"}, bus.push_flags, 0);
    check({tag, ".ack"},     bus.intr_ack, 0);
    check({tag, ".busy"},    bus.busy, 1);
    check({tag, ".masked"},  bus.intr_masked, 0);
    check({tag, ".scnt"},    bus.stall_cnt, 0);
  endtask

  task automatic check_outputs(input bit s, input bit sp, input bit br);
    logic       e_pc_en, e_ifen, e_iff, e_idf, e_pp, e_pf, e_ack, e_busy;
    logic [1:0] e_src;
    logic [7:0] e_vec;
    e_pc_en = 0; e_src = 0; e_vec = 0; e_ifen = 0; e_iff = 1; e_idf = 1;
    e_pp = 0; e_pf = 0; e_ack = 0; e_busy = 1;
    if (m_vecfetch) begin
      e_pc_en = 1; e_src = 2; e_vec = RV;
    end else if (m_pos < 0) begin
      e_busy = 0;
      if (br) begin
        e_pc_en = 1; e_src = 1; e_ifen = 1;
      end else begin
        e_pc_en = !sp; e_ifen = !s; e_iff = 0; e_idf = s;
      end
    end else if (m_pos < D) begin
      if (br) begin e_pc_en = 1; e_src = 1; end
    end else if (m_pos == D) begin
      e_pp = 1;
    end else if (m_pos == D + 1) begin
      e_pf = 1;
    end else begin
      e_pc_en = 1; e_src = 2; e_vec = IV; e_ack = 1;
    end
    check("pc_en",   bus.pc_en, e_pc_en);
    check("pc_src",  bus.pc_src, e_src);
    check("vec",     bus.vec_addr, e_vec);
    check("if_en",   bus.if_id_en, e_ifen);
    check("if_fl",   bus.if_id_flush, e_iff);
    check("id_fl",   bus.id_ex_flush, e_idf);
    check("push_pc", bus.push_pc, e_pp);
    check("push_fl", bus.push_flags, e_pf);
    check("ack",     bus.intr_ack, e_ack);
    check("busy",    bus.busy, e_busy);
    check("masked",  bus.intr_masked, m_masked);
    check("scnt",    bus.stall_cnt, exp_scnt());
  endtask

  task automatic model_update(input bit s, input bit sp, input bit br, input bit it, input bit rti);
    bit ack;
    bit pend_old;
    ack = (!m_vecfetch && m_pos == D + 2);
    pend_old = m_pend;
    if (!m_vecfetch && m_pos < 0 && !br && (s || sp) && m_scnt < 65535) m_scnt++;
    if (ack)                   m_pend = 1'b0;
    else if (it && !m_masked)  m_pend = 1'b1;
    if (ack)      m_masked = 1'b1;
    else if (rti) m_masked = 1'b0;
    if (m_vecfetch)           m_vecfetch = 1'b0;
    else if (m_pos < 0) begin
      if (!br && pend_old) m_pos = 0;
    end else if (ack)         m_pos = -1;
    else                      m_pos++;
  endtask

  task automatic step(input bit s, input bit sp, input bit br, input bit it, input bit rti);
    @(negedge clk);
    bus.stall = s; bus.stall_pc = sp; bus.branch_taken_ex = br;
    bus.intr = it; bus.rti_commit = rti;
    #1;
    check_outputs(s, sp, br);
    last_ack = bus.intr_ack;
    @(posedge clk);
    model_update(s, sp, br, it, rti);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int ack_step;
    bit reached;
    bus.stall = 0; bus.stall_pc = 0; bus.branch_taken_ex = 0;
    bus.intr = 0; bus.rti_commit = 0;
    model_reset();
    #3 check_reset("rst0");
    repeat (2) @(posedge clk);
    #1 check_reset("rst1");
    release_reset();

    // Reset vector fetch then RUN
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Two-cycle stall, then branch over stall
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // Interrupt pulse: ack lands D+4 steps after the sampling step
    step(0, 0, 0, 1, 0);
    ack_step = 0;
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0, 0, 0);
      if (last_ack && ack_step == 0) ack_step = k;
    end
    check("ack_latency", 16'(ack_step), 16'(D + 4));
    check("masked_after_isr", bus.intr_masked, 1);

    // intr held high: no re-entry while masked, re-entry after rti
    for (int k = 0; k < 15; k++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Reset asserted during PUSH_FLAGS
    step(0, 0, 0, 1, 0);
    reached = 0;
    for (int k = 0; k < 20 && !reached; k++) begin
      if (m_pos == D + 1) reached = 1;
      else step(0, 0, 0, 0, 0);
    end
    check("reach_push_flags", 16'(reached), 1);
    @(negedge clk);
    bus.intr = 0;
    #1;
    check("push_fl_before_rst", bus.push_flags, 1);
    rst_n = 1'b0;
    model_reset();
    #1 check_reset("rst_mid");
    release_reset();

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0,
           $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
